skid_slice: RTL and testbench

//  Two-entry valid/ready register slice (skid buffer) for the corner_detector pixel/score pipelines.

---
 rtl/skid_pkg.sv | 17 +
 rtl/sat_counter.sv | 22 ++
 rtl/skid_slice.sv | 125 ++++++++++++
 tb/tb_skid_slice.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// Shared state encodings for two-entry valid/ready stream stages.
// The state encoding doubles as the occupancy count.
package skid_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  typedef logic [1:0] skid_occ_t;

  function automatic skid_occ_t skid_occ(input skid_state_e s);
    return skid_occ_t'(s);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge c) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/skid_slice.sv
// Two-entry valid/ready register slice: out_valid, out_data and in_ready all come
// straight from flops, cutting both the forward and the reverse timing path.
module skid_slice
  import skid_pkg::*;
#(
  parameter int unsigned        WIDTH = 1,
  parameter logic [WIDTH-1:0]   INIT  = '0,
  parameter int unsigned        CNT_W = 16
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic             out_valid_q, in_ready_q;
  logic [1:0]       occ_q;
  logic             accept, emit, stall_inc;
  logic             main_ld, main_from_skid, skid_ld;

  always_comb begin
    accept    = in_valid & in_ready_q;
    emit      = out_valid_q & out_ready;
    stall_inc = out_valid_q & ~out_ready;
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      unique case (state_q)
        SKID_EMPTY: if (accept) state_d = SKID_ONE;
        SKID_ONE: begin
          if (accept && !emit) begin
            state_d = SKID_FULL;
          end else if (!accept && emit) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL:  if (emit) state_d = SKID_ONE;
        default:    state_d = SKID_EMPTY;
      endcase
    end
  end

  // Data-register load controls; flush suppresses every load so nothing accepted survives.
  always_comb begin
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (!flush) begin
      unique case (state_q)
        SKID_EMPTY: main_ld = accept;
        SKID_ONE: begin
          main_ld = accept & emit;
          skid_ld = accept & ~emit;
        end
        SKID_FULL: begin
          main_ld        = emit;
          main_from_skid = emit;
        end
        default: ;
      endcase
    end
    main_d = main_from_skid ? skid_q : in_data;
  end

  // Handshake flags are registered from the next state so they align with state_q.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      main_q      <= INIT;
      skid_q      <= INIT;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      occ_q       <= '0;
    end else begin
      out_valid_q <= (state_d != SKID_EMPTY);
      in_ready_q  <= (state_d != SKID_FULL);
      occ_q       <= skid_occ(state_d);
      if (flush) begin
        main_q <= INIT;
        skid_q <= INIT;
      end else begin
        if (main_ld) main_q <= main_d;
        if (skid_ld) skid_q <= in_data;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .c    (c),
    .rst_n(rst_n),
    .clr  (flush),
    .inc  (stall_inc),
    .q    (stall_cnt)
  );

  always_comb begin
    out_valid = out_valid_q;
    in_ready  = in_ready_q;
    out_data  = main_q;
    occupancy = occ_q;
  end

endmodule

// File: tb/tb_skid_slice.sv
// Bench for skid_slice: directed vector table, negedge scoreboard with hold checks,
// and a randomised valid/ready soak.
module tb_skid_slice;

  logic       c;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  skid_slice #(
    .WIDTH(8),
    .INIT (8'hA5),
    .CNT_W(4)
  ) dut (
    .c        (c),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       e_ov;
    logic       e_ir;
    logic [1:0] e_occ;
    logic [7:0] e_data;
    logic [3:0] e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int r, input int f, input int iv, input int d, input int ordy,
                              input int ov, input int ir, input int occ, input int data, input int st);
    vec_t v;
    v.rst_n     = r[0];
    v.flush     = f[0];
    v.in_valid  = iv[0];
    v.in_data   = d[7:0];
    v.out_ready = ordy[0];
    v.e_ov      = ov[0];
    v.e_ir      = ir[0];
    v.e_occ     = occ[1:0];
    v.e_data    = data[7:0];
    v.e_stall   = st[3:0];
    vecs.push_back(v);
  endfunction

  // Scoreboard: beats pushed on Accept, popped on Emit, both judged for the coming edge.
  logic [7:0] sb_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev  = '0;

  always @(negedge c) begin
    if (stall_prev) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data", 32'(out_data), 32'(data_prev));
    end
    stall_prev = rst_n && !flush && out_valid && !out_ready;
    data_prev  = out_data;
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: emitted %0h, expected no beat at %0t", out_data, $time);
        end else begin
          check("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  initial begin
    int   beats;
    int   cycles;
    logic acc;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset held 3 cycles with in_valid asserted, then release
    for (int i = 0; i < 3; i++) add(0, 0, 1, 'h77, 0, 0, 0, 0, 'hA5, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 'hA5, 0);
    // back-to-back streaming
    for (int k = 1; k <= 16; k++) add(1, 0, 1, k, 1, 1, 1, 1, k, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 'h10, 0);
    // backpressure to FULL then drain
    add(1, 0, 1, 'h0A, 0, 1, 1, 1, 'h0A, 0);
    add(1, 0, 1, 'h0B, 0, 1, 0, 2, 'h0A, 1);
    add(1, 0, 0, 0, 0, 1, 0, 2, 'h0A, 2);
    add(1, 0, 0, 0, 0, 1, 0, 2, 'h0A, 3);
    add(1, 0, 0, 0, 1, 1, 1, 1, 'h0B, 3);
    add(1, 0, 0, 0, 1, 0, 1, 0, 'h0B, 3);
    // flush while FULL and while ONE with a beat offered
    add(1, 0, 1, 'h21, 0, 1, 1, 1, 'h21, 3);
    add(1, 0, 1, 'h22, 0, 1, 0, 2, 'h21, 4);
    add(1, 1, 1, 'h0C, 0, 0, 1, 0, 'hA5, 0);
    add(1, 0, 1, 'h31, 0, 1, 1, 1, 'h31, 0);
    add(1, 1, 1, 'h0C, 1, 0, 1, 0, 'hA5, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 'hA5, 0);
    // stall counter saturation
    add(1, 0, 1, 'h41, 0, 1, 1, 1, 'h41, 0);
    for (int i = 1; i <= 20; i++) add(1, 0, 0, 0, 0, 1, 1, 1, 'h41, (i > 15) ? 15 : i);
    add(1, 0, 0, 0, 1, 0, 1, 0, 'h41, 15);
    // reset mid-transfer, also overriding flush
    add(1, 0, 1, 'h51, 0, 1, 1, 1, 'h51, 15);
    add(1, 0, 1, 'h52, 0, 1, 0, 2, 'h51, 15);
    add(0, 1, 1, 'h53, 1, 0, 0, 0, 'hA5, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 'hA5, 0);

    foreach (vecs[i]) begin
      rst_n     = vecs[i].rst_n;
      flush     = vecs[i].flush;
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      @(posedge c);
      #1;
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d.occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      check($sformatf("v%0d.out_data", i), 32'(out_data), 32'(vecs[i].e_data));
      check($sformatf("v%0d.stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_stall));
    end

    // random soak; in_valid/in_data held until accepted
    rst_n    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    beats    = 0;
    cycles   = 0;
    while (beats < 10000 && cycles < 60000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      acc = in_valid && in_ready;
      @(posedge c);
      #1;
      cycles++;
      if (acc) begin
        beats++;
        in_valid = 1'b0;
      end
    end
    check("rand_beats", 32'(beats), 32'd10000);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge c);
      #1;
    end
    check("drain_occupancy", 32'(occupancy), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    @(negedge c);
    #1;
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
